// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the responder state set used by the memory slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        BYTE = 3'd0,
        HALF = 3'd1,
        WORD = 3'd2
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    // Half-words need an even address and words a 4-byte aligned one.
    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] a);
        return ((size == HALF) && a[0]) || ((size == WORD) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/ahb_byte_strobe.sv
// Little-endian byte-lane enables for a transfer of the given size at the given offset.
module ahb_byte_strobe
    import ahb_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_i,
    output logic [3:0] strb_o
);

    always_comb begin
        strb_o = 4'b0000;
        case (hsize_i)
            BYTE:    strb_o = 4'b0001 << addr_i;
            HALF:    strb_o = addr_i[1] ? 4'b1100 : 4'b0011;
            WORD:    strb_o = 4'b1111;
            default: strb_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory responder: word-organised RAM, programmable wait states and a
// two-cycle ERROR response for out-of-range, oversized or misaligned accesses.
module ahb_lite_mem_slave
    import ahb_pkg::*;
#(
    parameter int ADDRWIDTH   = 32,
    parameter int DATAWIDTH   = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 HSEL,
    input  logic [ADDRWIDTH-1:0] HADDR,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic [1:0]           HTRANS,
    input  logic                 HREADY,
    input  logic [DATAWIDTH-1:0] HWDATA,
    output logic [DATAWIDTH-1:0] HRDATA,
    output logic                 HREADYOUT,
    output logic                 HRESP
);

    localparam int              IDXW  = $clog2(MEM_WORDS);
    localparam logic [ADDRWIDTH:0] LIMIT = (ADDRWIDTH+1)'(MEM_WORDS * 4);
    localparam logic [3:0]      WS    = 4'(WAIT_STATES);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IDXW+1:0] addr_q, addr_d;
    logic            write_q, write_d;
    logic [2:0]      size_q, size_d;

    logic [DATAWIDTH-1:0] mem_q [MEM_WORDS];
    logic [3:0]           strb;
    logic [IDXW-1:0]      idx;
    logic                 can_accept;
    logic                 accept;
    logic                 bad;

    assign idx = addr_q[IDXW+1:2];

    // A new address phase is only taken while this slave is not stalling the bus.
    assign can_accept = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
    assign accept     = HSEL && HREADY && can_accept
                        && ((HTRANS == NONSEQ) || (HTRANS == SEQ));
    assign bad        = ({1'b0, HADDR} >= LIMIT) || (HSIZE > 3'd2)
                        || misaligned(HSIZE, HADDR[1:0]);

    ahb_byte_strobe u_strobe (
        .hsize_i (size_q),
        .addr_i  (addr_q[1:0]),
        .strb_o  (strb)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    addr_d  = HADDR[IDXW+1:0];
                    write_d = HWRITE;
                    size_d  = HSIZE;
                    if (bad) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
        endcase
    end

    // Write data arrives in the final data-phase cycle and commits on its closing edge.
    always_ff @(posedge HCLK) begin
        if ((state_q == S_DATA) && write_q) begin
            for (int i = 0; i < DATAWIDTH/8; i++) begin
                if (strb[i]) mem_q[idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    always_comb begin
        HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
        HRESP     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        HRDATA    = '0;
        if ((state_q == S_DATA) && !write_q) HRDATA = mem_q[idx];
    end

endmodule
